fp_mul_pipe: RTL
================

# fp_mul_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier. Configurable exponent and fraction widths, five rounding modes, and a valid/ready stream interface with full-pipeline back-pressure. Sits in the ALU datapath beside the other FP units. Uses flush-to-zero: subnormal operands and subnormal results are treated as zero.

## Interface
- `EXP_W`, default 8: exponent width; bias = 2^(EXP_W-1)-1.
- `FRC_W`, default 23: stored fraction width; word width W = 1+EXP_W+FRC_W.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  unit accepts the beat this cycle.
- `fp_X`, `fp_Y`  in  W  operands.
- `r_mode`  in  3  rounding mode, captured with the operands:
  - 000 RNE
  - 001 RTZ
  - 010 RDN
  - 011 RUP
  - 100 RMM
  - others are treated as RNE.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `fp_Z`  out  W  product.
- `ovrf`  out  1  overflow flag; qualified by `out_valid`.
- `udrf`  out  1  underflow flag; qualified by `out_valid`.
- `nv`  out  1  invalid flag; present only when `FP_MUL_NV_FLAG_EN` is defined.

## Operation
- Operand classes:
  - exp==0 → zero (the fraction is ignored).
  - exp==all-ones, frc==0 → infinity.
  - exp==all-ones, frc!=0 → NaN.
  - anything else → normal.
- Sign of the result is always sX^sY, except for NaN results.
- Special cases, highest priority first:
  - any NaN operand, or zero×inf → canonical NaN {0, all-ones exp, frc MSB 1, rest 0}.
  - inf × (inf or normal) → signed infinity.
  - zero × (zero or normal) → signed zero.
  - Special results raise no `ovrf`/`udrf`.
- Normal × normal:
  - Product P = {1,frcX}×{1,frcY}, width 2·FRC_W+2.
  - If P[MSB] is set, the exponent increments; otherwise P shifts left 1.
  - Keep FRC_W+1 significand bits, then guard bit G and sticky S = OR of the rest.
  - Exponent E = eX+eY−bias+norm, computed signed with EXP_W+2 bits.
- Rounding increment, applied only when inexact (G|S):
  - RNE: G&(S|lsb).
  - RTZ: 0.
  - RDN: sign.
  - RUP: !sign.
  - RMM: G.
- If the increment carries out of the significand, the fraction becomes 0 and E increments.
- Overflow is E ≥ all-ones after rounding. It sets `ovrf`=1 and the result depends on mode:
  - RNE, RMM → ±inf.
  - RTZ → ±max finite.
  - RDN → +max finite or −inf.
  - RUP → +inf or −max finite.
- Underflow is E ≤ 0 after rounding. Result is signed zero, `udrf`=1, for every mode.

## Timing
- Three stages:
  - S1: classify and multiply.
  - S2: normalise, guard and sticky.
  - S3: round, pack and flags.
- Latency: result appears on `out_valid` 3 cycles after the accepting edge.
- Throughput: 1 result per cycle.
- Global stall: `adv` = !out_valid | out_ready.
  - `in_ready` = `adv`, combinational.
  - All stages hold when `adv`=0.
  - A beat transfers when valid&ready on the edge.
- While stalled, `fp_Z`, `ovrf`, `udrf` and `nv` stay stable and `out_valid` stays 1.
- An empty pipeline bubble (stage valid 0) does not block the stages behind it only through `adv`. Bubbles are not collapsed.
- Reset value 0 for:
  - all stage valid bits
  - `out_valid`
  - `fp_Z`
  - `ovrf`, `udrf`, `nv`
- Reset mid-operation discards all in-flight beats. `in_ready` is 1 in the first cycle after reset release.
- Simultaneous accept at the input and drain at the output in one cycle is legal: no loss, no duplication.

## Configuration
- `FP_MUL_NV_FLAG_EN` defined:
  - port `nv` exists.
  - `nv`=1 when an input is a signalling NaN (frc MSB 0), or for zero×inf. Quiet NaN inputs give `nv`=0.
  - `nv` is pipelined with the result.
- `FP_MUL_NV_FLAG_EN` undefined:
  - port `nv` and its logic are absent.
  - `fp_Z`, `ovrf`, `udrf` and timing are identical.

## Test plan
All scenarios use defaults EXP_W=8, FRC_W=23, and `out_ready`=1 unless stated.
- 3.0×3.0 exactness: 0x40400000×0x40400000, r_mode=001 → `fp_Z`=0x41100000 exactly 3 cycles after accept; `ovrf`=`udrf`=0.
- Rounding: 0xC0000000×0x40490FDB (−2×π), RNE → 0xC0C90FDB.
- Rounding: 0x3F800001×0x3F800001 →
  - 0x3F800002 under RNE, RTZ and RDN.
  - 0x3F800003 under RUP.
- Overflow: 0x7F000000×0x7F000000 →
  - RNE: 0x7F800000, `ovrf`=1.
  - RTZ: 0x7F7FFFFF, `ovrf`=1.
  - Negated X under RUP: 0xFF7FFFFF.
- Underflow and specials:
  - 0x00800000×0x3F000000 → 0x00000000, `udrf`=1.
  - 0x00000001×0x40000000 → 0x00000000, no flags.
  - 0x7F800000×0x00000000 → 0x7FC00000, `nv`=1 when enabled.
  - 0xFF800000×0x40000000 → 0xFF800000.
- Back-pressure: stream 6 back-to-back products with `out_ready` low for cycles 4–7 → `in_ready` low while full, outputs held stable, all 6 results in order with none dropped. Assert `rst_n`=0 mid-stream → `out_valid`=0 immediately and no stale results after release.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined flush-to-zero FP multiplier with valid/ready stream; FP_MUL_NV_FLAG_EN adds the nv flag
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23,
  localparam int W = 1 + EXP_W + FRC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] fp_X,
  input  logic [W-1:0] fp_Y,
  input  logic [2:0]   r_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] fp_Z,
  output logic         ovrf,
  output logic         udrf
`ifdef FP_MUL_NV_FLAG_EN
  ,
  output logic         nv
`endif
);
  localparam int PW = 2 * FRC_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0] ONES = '1;
  localparam logic [EXP_W-1:0] EMAX = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [XW-1:0] BIAS = XW'(2 ** (EXP_W - 1) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, ONES, 1'b1, {(FRC_W-1){1'b0}}};

  logic adv;
  logic v0, v1, v2;
  logic [W-1:0] x0, y0;
  logic [2:0] m0, m1, m2;
  logic s1, sp1, s2, sp2;
  logic [W-1:0] spr1, spr2;
  logic [XW-1:0] e1, e2;
  logic [PW-1:0] p1;
  logic [FRC_W-1:0] f2;
  logic g2, t2;

  assign adv = !out_valid | out_ready;
  assign in_ready = adv;

  logic sx, sy, zx, zy, ix, iy, nx, ny, zi, nan, inf, sgn;
  logic [EXP_W-1:0] ex, ey;
  logic [FRC_W-1:0] fx, fy;
  assign {sx, ex, fx} = x0;
  assign {sy, ey, fy} = y0;
  assign zx = ex == '0;
  assign zy = ey == '0;
  assign ix = ex == ONES && fx == '0;
  assign iy = ey == ONES && fy == '0;
  assign nx = ex == ONES && fx != '0;
  assign ny = ey == ONES && fy != '0;
  assign zi = (zx & iy) | (ix & zy);
  assign nan = nx | ny | zi;
  assign inf = ix | iy;
  assign sgn = sx ^ sy;

  logic [PW-2:0] pn;
  assign pn = p1[PW-1] ? p1[PW-2:0] : {p1[PW-3:0], 1'b0};

  logic inc, cy, ov, un, to_max;
  logic [FRC_W-1:0] fr;
  logic [XW-1:0] ef;
  logic [W-1:0] res;
  assign inc = (g2 | t2) & (m2 == 3'd1 ? 1'b0 : m2 == 3'd2 ? s2 : m2 == 3'd3 ? !s2 :
                            m2 == 3'd4 ? g2 : g2 & (t2 | f2[0]));
  assign {cy, fr} = {1'b0, f2} + {{FRC_W{1'b0}}, inc};
  assign ef = e2 + {{(XW-1){1'b0}}, cy};
  assign ov = $signed(ef) >= $signed({2'b00, ONES});
  assign un = $signed(ef) <= $signed({XW{1'b0}});
  assign to_max = m2 == 3'd1 | (m2 == 3'd2 & !s2) | (m2 == 3'd3 & s2);
  assign res = sp2 ? spr2 :
               ov ? (to_max ? {s2, EMAX, {FRC_W{1'b1}}} : {s2, ONES, {FRC_W{1'b0}}}) :
               un ? {s2, {(W-1){1'b0}}} : {s2, ef[EXP_W-1:0], fr};

  // stage valid bits shift together so bubbles are kept, not collapsed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {v0, v1, v2, out_valid} <= '0;
    else if (adv) {v0, v1, v2, out_valid} <= {in_valid, v0, v1, v2};

  // operand capture, classify/multiply, then normalise with guard and sticky
  always_ff @(posedge clk)
    if (adv) begin
      x0 <= fp_X;
      y0 <= fp_Y;
      m0 <= r_mode;
      s1 <= sgn;
      sp1 <= nan | inf | zx | zy;
      spr1 <= nan ? QNAN : inf ? {sgn, ONES, {FRC_W{1'b0}}} : {sgn, {(W-1){1'b0}}};
      m1 <= m0;
      e1 <= XW'(ex) + XW'(ey) - BIAS;
      p1 <= PW'({1'b1, fx}) * PW'({1'b1, fy});
      s2 <= s1;
      sp2 <= sp1;
      spr2 <= spr1;
      m2 <= m1;
      e2 <= e1 + {{(XW-1){1'b0}}, p1[PW-1]};
      f2 <= pn[PW-2 -: FRC_W];
      g2 <= pn[FRC_W];
      t2 <= |pn[FRC_W-1:0];
    end

  // round, pack and flag into the output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fp_Z <= '0;
      ovrf <= 1'b0;
      udrf <= 1'b0;
    end else if (adv) begin
      fp_Z <= res;
      ovrf <= !sp2 & ov;
      udrf <= !sp2 & !ov & un;
    end

`ifdef FP_MUL_NV_FLAG_EN
  logic nv1, nv2;
  // invalid flag travels alongside its result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {nv1, nv2, nv} <= '0;
    else if (adv) {nv1, nv2, nv} <= {(nx & !fx[FRC_W-1]) | (ny & !fy[FRC_W-1]) | zi, nv1, nv2};
`endif
endmodule
